// File: rtl/fft_inplace_sequencer_if.sv
// Bus bundle for fft_inplace_sequencer.
// Groups three channels: the sample input stream, the operand/result exchange with an
// external radix-2 DIT butterfly, and the spectrum output stream.
//   master : the sequencer side (drives in_ready, bf_* operands, tw_index, out_*, busy)
//   slave  : the environment side (drives in_*, butterfly results, bf_valid, out_ready)
interface fft_inplace_sequencer_if #(
  parameter int unsigned bit_width  = 16,
  parameter int unsigned addr_width = 3
);
  // Input sample stream
  logic                          in_valid;
  logic signed [bit_width-1:0]   in_re;
  logic signed [bit_width-1:0]   in_im;
  logic                          in_ready;
  // Butterfly operands and twiddle index
  logic                          bf_en;
  logic signed [bit_width-1:0]   bf_re1;
  logic signed [bit_width-1:0]   bf_im1;
  logic signed [bit_width-1:0]   bf_re2;
  logic signed [bit_width-1:0]   bf_im2;
  logic        [addr_width-2:0]  tw_index;
  // Butterfly results
  logic                          bf_valid;
  logic signed [bit_width-1:0]   bf_re_o1;
  logic signed [bit_width-1:0]   bf_im_o1;
  logic signed [bit_width-1:0]   bf_re_o2;
  logic signed [bit_width-1:0]   bf_im_o2;
  // Output spectrum stream
  logic                          out_valid;
  logic                          out_ready;
  logic signed [bit_width-1:0]   out_re;
  logic signed [bit_width-1:0]   out_im;
  logic                          out_last;
  logic                          busy;

  modport master (
    input  in_valid, in_re, in_im,
    output in_ready,
    output bf_en, bf_re1, bf_im1, bf_re2, bf_im2, tw_index,
    input  bf_valid, bf_re_o1, bf_im_o1, bf_re_o2, bf_im_o2,
    output out_valid, out_re, out_im, out_last, busy,
    input  out_ready
  );

  modport slave (
    output in_valid, in_re, in_im,
    input  in_ready,
    input  bf_en, bf_re1, bf_im1, bf_re2, bf_im2, tw_index,
    output bf_valid, bf_re_o1, bf_im_o1, bf_re_o2, bf_im_o2,
    input  out_valid, out_re, out_im, out_last, busy,
    output out_ready
  );
endinterface

// File: rtl/fft_inplace_sequencer.sv
// In-place radix-2 DIT FFT sequencer.
// Loads one N-point complex frame in bit-reversed order, issues every butterfly pair of
// every stage to an external butterfly, writes the results back in place, then streams
// the spectrum out in natural order.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, asserted HIGH despite the name
//   bus   : fft_inplace_sequencer_if.master (input stream, butterfly exchange, output stream)
module fft_inplace_sequencer #(
  parameter int unsigned bit_width  = 16,
  parameter int unsigned N          = 8,
  parameter int unsigned addr_width = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  fft_inplace_sequencer_if.master bus
);

  localparam int unsigned TwW = addr_width - 1;
  localparam logic [addr_width-1:0] IdxMax  = '1;
  localparam logic [addr_width-2:0] PairMax = '1;
  localparam logic [addr_width-1:0] AwM1    = addr_width'(addr_width - 1);

  typedef enum logic [1:0] {StLoad, StCompute, StOutput} state_e;

  state_e                 state_q, state_d;
  logic [addr_width-1:0]  idx_q, idx_d;      // sample index i (LOAD) / j (OUTPUT)
  logic [addr_width-2:0]  pair_q, pair_d;    // pair index p within a stage
  logic [addr_width-1:0]  stage_q, stage_d;  // stage s

  logic [bit_width-1:0] mem_re [N];
  logic [bit_width-1:0] mem_im [N];

  function automatic logic [addr_width-1:0] bitrev(input logic [addr_width-1:0] a);
    for (int b = 0; b < int'(addr_width); b++) begin
      bitrev[b] = a[int'(addr_width) - 1 - b];
    end
  endfunction

  // Pair addressing: half = 2^s, k = p mod half, top = (p >> s) * 2 * half + k.
  logic [addr_width-1:0] pair_ext, half, k, top, bot;
  logic [TwW-1:0]        tw;
  logic                  last_stage, last_pair;

  assign pair_ext   = addr_width'(pair_q);
  assign half       = addr_width'(1) << stage_q;
  assign k          = pair_ext & (half - 1'b1);
  assign top        = (((pair_ext >> stage_q) << stage_q) << 1) | k;
  assign bot        = top + half;
  assign tw         = TwW'(k << (AwM1 - stage_q));
  assign last_stage = (stage_q == AwM1);
  assign last_pair  = (pair_q == PairMax);

  // State and counter registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StLoad;
      idx_q   <= '0;
      pair_q  <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pair_q  <= pair_d;
      stage_q <= stage_d;
    end
  end

  // Frame storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (state_q == StLoad && bus.in_valid) begin
      mem_re[bitrev(idx_q)] <= bus.in_re;
      mem_im[bitrev(idx_q)] <= bus.in_im;
    end else if (state_q == StCompute && bus.bf_valid) begin
      mem_re[top] <= bus.bf_re_o1;
      mem_im[top] <= bus.bf_im_o1;
      mem_re[bot] <= bus.bf_re_o2;
      mem_im[bot] <= bus.bf_im_o2;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:    if (bus.in_valid && idx_q == IdxMax) state_d = StCompute;
      StCompute: if (bus.bf_valid && last_pair && last_stage) state_d = StOutput;
      StOutput:  if (bus.out_ready && idx_q == IdxMax) state_d = StLoad;
      default:   state_d = StLoad;
    endcase
  end

  // Counter next-state
  always_comb begin
    idx_d   = idx_q;
    pair_d  = pair_q;
    stage_d = stage_q;
    unique case (state_q)
      StLoad: begin
        pair_d  = '0;
        stage_d = '0;
        if (bus.in_valid) idx_d = idx_q + 1'b1;
      end
      StCompute: begin
        if (bus.bf_valid) begin
          pair_d = pair_q + 1'b1;  // wraps to 0 after N/2-1
          if (last_pair) stage_d = last_stage ? '0 : stage_q + 1'b1;
        end
      end
      StOutput: if (bus.out_ready) idx_d = idx_q + 1'b1;  // wraps to 0 for the next load
      default: ;
    endcase
  end

  // Outputs; data ports are forced to zero outside their owning state
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.bf_en     = 1'b0;
    bus.bf_re1    = '0;
    bus.bf_im1    = '0;
    bus.bf_re2    = '0;
    bus.bf_im2    = '0;
    bus.tw_index  = '0;
    bus.out_valid = 1'b0;
    bus.out_re    = '0;
    bus.out_im    = '0;
    bus.out_last  = 1'b0;
    bus.busy      = 1'b0;
    unique case (state_q)
      StLoad: bus.in_ready = 1'b1;
      StCompute: begin
        bus.bf_en    = 1'b1;
        bus.bf_re1   = mem_re[top];
        bus.bf_im1   = mem_im[top];
        bus.bf_re2   = mem_re[bot];
        bus.bf_im2   = mem_im[bot];
        bus.tw_index = tw;
        bus.busy     = 1'b1;
      end
      StOutput: begin
        bus.out_valid = 1'b1;
        bus.out_re    = mem_re[idx_q];
        bus.out_im    = mem_im[idx_q];
        bus.out_last  = (idx_q == IdxMax);
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
